// File: rtl/conv_maxpool_2x2.sv
// conv_maxpool_2x2
//   Streaming 2x2 / stride-2 max-pool stage that sits behind conv_top.
//   Pixels arrive in raster order, one per valid beat, with no backpressure.
//   A pooled pixel is emitted one cycle after the beat that completes its
//   window (odd row, odd column). One line buffer of IMG_W/2 entries holds
//   the horizontal pair maxima of the even row of each window pair.
//
//   Optional build macro: MAXPOOL_RELU_EN
//     When defined, negative pooled results are clamped to zero before the
//     output register. When undefined, the raw signed maximum is passed on.
//
// Parameters
//   DATA_W : pixel width, signed two's complement
//   IMG_W  : input frame width in pixels (>= 2)
//   IMG_H  : input frame height in pixels (>= 2)
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   data_i       : convolution result pixel
//   valid_i      : data_i valid this cycle (gaps allowed)
//   data_o       : pooled pixel, held while valid_o is low
//   valid_o      : one-cycle pulse per pooled pixel
//   frame_done_o : one-cycle pulse marking the end of a pooled frame
module conv_maxpool_2x2 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_H - 1);
  // Position of the beat that completes the bottom-right pooled window.
  localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'(2 * (IMG_W / 2) - 1);
  localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'(2 * (IMG_H / 2) - 1);
  localparam bit               H_ODD        = (IMG_H % 2) != 0;

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] pair_lat;
  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] win_max;
  logic signed [DATA_W-1:0] result;
  logic signed [DATA_W-1:0] linebuf [LB_D];
  logic [LB_AW-1:0]         lb_idx;
  logic                     lb_wr;
  logic                     win_done;
  logic                     frame_end;

  always_comb begin
    pix      = data_i;
    lb_idx   = LB_AW'(col >> 1);
    lb_rd    = linebuf[lb_idx];
    pair_max = (pix > pair_lat) ? pix : pair_lat;
    win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
`ifdef MAXPOOL_RELU_EN
    result   = win_max[DATA_W-1] ? '0 : win_max;
`else
    result   = win_max;
`endif
    // An odd trailing column/row is always at an even index, so the odd-bit
    // qualifiers below ignore it without extra logic.
    lb_wr    = valid_i && !row[0] && col[0];
    win_done = valid_i && row[0] && col[0];
    // With odd IMG_H the frame ends on the discarded last row, so the done
    // pulse follows the final input beat instead of the final window.
    if (H_ODD) begin
      frame_end = valid_i && (row == ROW_LAST) && (col == COL_LAST);
    end else begin
      frame_end = win_done && (row == WIN_ROW_LAST) && (col == WIN_COL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col          <= '0;
      row          <= '0;
      pair_lat     <= '0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      valid_o      <= win_done;
      frame_done_o <= frame_end;
      if (win_done) begin
        data_o <= result;
      end
      if (valid_i) begin
        if (!col[0]) begin
          pair_lat <= pix;
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Every entry is rewritten on an even row before the odd row reads it,
  // so the line buffer carries no reset.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Testbench for conv_maxpool_2x2: a 4x4 and a 5x5 instance driven from a
// table of per-beat records with hand-computed expected outputs, plus a
// hand-written mid-frame reset sequence.
module tb_conv_maxpool_2x2;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d4_in, d5_in, d4_out, d5_out;
  logic          v4_in, v5_in, v4_out, v5_out, fd4, fd5;

  always #5 clk = ~clk;

  conv_maxpool_2x2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst(rst), .data_i(d4_in), .valid_i(v4_in),
    .data_o(d4_out), .valid_o(v4_out), .frame_done_o(fd4)
  );

  conv_maxpool_2x2 #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk(clk), .rst(rst), .data_i(d5_in), .valid_i(v5_in),
    .data_o(d5_out), .valid_o(v5_out), .frame_done_o(fd5)
  );

  typedef struct {
    bit            sel;   // 0: 4x4 instance, 1: 5x5 instance
    logic [DW-1:0] pix;
    int            gap;   // idle cycles after the beat
    bit            ev;    // expected valid_o one cycle after the beat
    logic [DW-1:0] ed;    // expected data_o when ev
    bit            efd;   // expected frame_done_o one cycle after the beat
  } vec_t;

  vec_t          tbl[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_last [2];

  function automatic int pool_exp(int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic void add(bit sel, int pix, int gap, bit ev, int ed, bit efd);
    vec_t v;
    v.sel = sel;
    v.pix = DW'(pix);
    v.gap = gap;
    v.ev  = ev;
    v.ed  = DW'(pool_exp(ed));
    v.efd = efd;
    tbl.push_back(v);
  endfunction

  // 4x4 frame of base+i: every window maximum is its bottom-right pixel.
  function automatic void add_ramp4(int base, bit gaps);
    for (int i = 0; i < 16; i++) begin
      bit ev;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      add(1'b0, base + i, gaps ? int'($urandom_range(0, 3)) : 0, ev, base + i, i == 15);
    end
  endfunction

  task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, $signed(act), $signed(exp));
    end
  endtask

  task automatic sample(input bit s, output logic [DW-1:0] d, output logic v, output logic fd);
    if (s) begin
      d = d5_out; v = v5_out; fd = fd5;
    end else begin
      d = d4_out; v = v4_out; fd = fd4;
    end
  endtask

  task automatic beat(input vec_t t, input int idx);
    logic [DW-1:0] d;
    logic          v, fd;
    @(negedge clk);
    if (t.sel) begin d5_in = t.pix; v5_in = 1'b1; end
    else       begin d4_in = t.pix; v4_in = 1'b1; end
    @(posedge clk);
    #1;
    v4_in = 1'b0;
    v5_in = 1'b0;
    if (t.ev) exp_last[t.sel] = t.ed;
    sample(t.sel, d, v, fd);
    chk("valid", idx, DW'(v), DW'(t.ev));
    chk("frame_done", idx, DW'(fd), DW'(t.efd));
    chk("data", idx, d, exp_last[t.sel]);
    for (int g = 0; g < t.gap; g++) begin
      @(posedge clk);
      #1;
      sample(t.sel, d, v, fd);
      chk("gap_valid", idx, DW'(v), '0);
      chk("gap_frame_done", idx, DW'(fd), '0);
      chk("gap_hold", idx, d, exp_last[t.sel]);
    end
  endtask

  initial begin
    int mixed [16];
    int mix_ev [16];
    rst   = 1'b0;
    d4_in = '0; d5_in = '0;
    v4_in = 1'b0; v5_in = 1'b0;
    exp_last[0] = '0;
    exp_last[1] = '0;

    // Window maxima: 10 (linebuf side), 7 (tie), -5 (signed), 100 (vs -50 unsigned trap).
    mixed  = '{10, -3, 7, 7, -20, 4, -1, 2, -5, -6, 100, -50, -7, -8, 3, 99};
    mix_ev = '{0, 0, 0, 0, 0, 10, 0, 7, 0, 0, 0, 0, 0, -5, 0, 100};

    add_ramp4(0, 1'b0);            // frame 0..15 continuous
    add_ramp4(16, 1'b0);           // back-to-back second frame
    add_ramp4(0, 1'b1);            // same frame with 0-3 cycle gaps
    add_ramp4(-100, 1'b0);         // all negative
    for (int i = 0; i < 16; i++) begin
      bit ev;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      add(1'b0, mixed[i], i % 2, ev, mix_ev[i], i == 15);
    end
    // 5x5: windows complete at beats 6, 8, 16, 18; done pulses alone after 24.
    for (int i = 0; i < 25; i++) begin
      bit ev;
      ev = (i == 6) || (i == 8) || (i == 16) || (i == 18);
      add(1'b1, i, 0, ev, i, i == 24);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid4", 0, DW'(v4_out), '0);
    chk("rst_fd4", 0, DW'(fd4), '0);
    chk("rst_data4", 0, d4_out, '0);
    chk("rst_valid5", 0, DW'(v5_out), '0);
    chk("rst_fd5", 0, DW'(fd5), '0);
    chk("rst_data5", 0, d5_out, '0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) beat(tbl[i], i);

    // Mid-frame reset: 6 pixels, the last completes a window, then reset
    // while valid_o is high; it must clear at once.
    tbl.delete();
    add_ramp4(0, 1'b0);
    for (int i = 0; i < 6; i++) beat(tbl[i], 1000 + i);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 0, DW'(v4_out), '0);
    chk("async_rst_data", 0, d4_out, '0);
    chk("async_rst_fd", 0, DW'(fd4), '0);
    exp_last[0] = '0;
    exp_last[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) beat(tbl[i], 2000 + i);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
